// File: rtl/car_game_pkg.sv
// Shared definitions for the car game video pipeline: game FSM states,
// the transparent colour code and the visible-area geometry.
package car_game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    INVULN = 2'd2,
    OVER   = 2'd3
  } game_state_t;

  localparam logic [11:0] TRANSPARENT = 12'h000;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

endpackage

// File: rtl/frame_overlap_counter.sv
// Counts player/obstacle overlapping pixels within one frame (saturating)
// and produces the frame-boundary tick together with the hit decision.
module frame_overlap_counter #(
  parameter int CNT_W         = 12,
  parameter int HIT_THRESHOLD = 16,
  parameter int V_ACTIVE      = car_game_pkg::V_ACTIVE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [9:0]  pix_row,
  input  logic [9:0]  pix_col,
  input  logic        video_on,
  input  logic [11:0] obstacle_pix,
  input  logic [11:0] player_pix,
  output logic        tick,
  output logic        hit_frame
);
  import car_game_pkg::*;

  logic [CNT_W-1:0] overlap_cnt;
  logic             overlap;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign overlap   = video_on && (obstacle_pix != TRANSPARENT) && (player_pix != TRANSPARENT);
  // The tick pixel sits outside the visible area, so it never adds to the count.
  assign tick      = (pix_row == 10'(V_ACTIVE)) && (pix_col == 10'd0);
  assign hit_frame = (overlap_cnt >= CNT_W'(HIT_THRESHOLD));

  // Per-frame overlap count: cleared by reset, game restart or frame tick.
  always_ff @(posedge clk) begin
    if (reset || clear || tick) begin
      overlap_cnt <= '0;
    end else if (overlap) begin
      overlap_cnt <= sat_inc(overlap_cnt);
    end
  end

endmodule

// File: rtl/car_collision_monitor.sv
// Collision monitor: turns per-frame overlap results into hit pulses, lives
// bookkeeping, a post-hit invulnerability window and the game-over flag.
module car_collision_monitor #(
  parameter int INIT_LIVES    = 3,
  parameter int HIT_THRESHOLD = 16,
  parameter int INVULN_FRAMES = 60,
  parameter int V_ACTIVE      = car_game_pkg::V_ACTIVE,
  parameter int CNT_W         = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pix_row,
  input  logic [9:0]  pix_col,
  input  logic        video_on,
  input  logic [11:0] obstacle_pix,
  input  logic [11:0] player_pix,
  input  logic        start,
  output logic        collision_pulse,
  output logic [1:0]  lives,
  output logic        invuln,
  output logic        flash,
  output logic        game_over
);
  import car_game_pkg::*;

  localparam int INV_W = $clog2(INVULN_FRAMES + 1);

  logic             tick;
  logic             hit_frame;
  logic             restart;

  game_state_t      state_p1, state_n;
  logic [1:0]       lives_p1, lives_n;
  logic [INV_W-1:0] inv_cnt_p1, inv_n;
  logic             pulse_p1, pulse_n;

  frame_overlap_counter #(
    .CNT_W         (CNT_W),
    .HIT_THRESHOLD (HIT_THRESHOLD),
    .V_ACTIVE      (V_ACTIVE)
  ) u_overlap (
    .clk          (clk),
    .reset        (reset),
    .clear        (restart),
    .pix_row      (pix_row),
    .pix_col      (pix_col),
    .video_on     (video_on),
    .obstacle_pix (obstacle_pix),
    .player_pix   (player_pix),
    .tick         (tick),
    .hit_frame    (hit_frame)
  );

  // State register together with the lives, invulnerability and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1   <= IDLE;
      lives_p1   <= 2'(INIT_LIVES);
      inv_cnt_p1 <= '0;
      pulse_p1   <= 1'b0;
    end else begin
      state_p1   <= state_n;
      lives_p1   <= lives_n;
      inv_cnt_p1 <= inv_n;
      pulse_p1   <= pulse_n;
    end
  end

  // Next-state logic; start in IDLE/OVER takes priority over a same-cycle tick.
  always_comb begin
    state_n = state_p1;
    lives_n = lives_p1;
    inv_n   = inv_cnt_p1;
    pulse_n = 1'b0;
    restart = 1'b0;
    case (state_p1)
      IDLE: begin
        if (start) begin
          state_n = PLAY;
          lives_n = 2'(INIT_LIVES);
          inv_n   = '0;
        end
      end
      PLAY: begin
        if (tick && hit_frame) begin
          pulse_n = 1'b1;
          if (lives_p1 > 2'd1) begin
            lives_n = lives_p1 - 2'd1;
            inv_n   = INV_W'(INVULN_FRAMES);
            state_n = INVULN;
          end else begin
            lives_n = 2'd0;
            state_n = OVER;
          end
        end
      end
      INVULN: begin
        if (tick) begin
          if (inv_cnt_p1 <= INV_W'(1)) begin
            inv_n   = '0;
            state_n = PLAY;
          end else begin
            inv_n = inv_cnt_p1 - 1'b1;
          end
        end
      end
      OVER: begin
        if (start) begin
          state_n = PLAY;
          lives_n = 2'(INIT_LIVES);
          inv_n   = '0;
          restart = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    collision_pulse = pulse_p1;
    lives           = lives_p1;
    invuln          = (state_p1 == INVULN);
    flash           = (state_p1 == INVULN) && inv_cnt_p1[2];
    game_over       = (state_p1 == OVER);
  end

endmodule

// File: tb/tb_car_collision_monitor.sv
// Randomized self-checking bench for car_collision_monitor with a
// game-rule reference model.
module tb_car_collision_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  pix_row = 10'd500;
  logic [9:0]  pix_col = 10'd5;
  logic        video_on = 1'b0;
  logic [11:0] obstacle_pix = 12'h000;
  logic [11:0] player_pix = 12'h000;
  logic        start = 1'b0;
  logic        collision_pulse;
  logic [1:0]  lives;
  logic        invuln;
  logic        flash;
  logic        game_over;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: game described in terms of rules, not FSM encoding.
  int m_count    = 0;
  bit m_playing  = 0;
  bit m_over     = 0;
  int m_lives    = 3;
  int m_inv_left = 0;
  bit m_pulse    = 0;

  car_collision_monitor dut (
    .clk             (clk),
    .reset           (reset),
    .pix_row         (pix_row),
    .pix_col         (pix_col),
    .video_on        (video_on),
    .obstacle_pix    (obstacle_pix),
    .player_pix      (player_pix),
    .start           (start),
    .collision_pulse (collision_pulse),
    .lives           (lives),
    .invuln          (invuln),
    .flash           (flash),
    .game_over       (game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] dut_vec();
    return {collision_pulse, lives, invuln, flash, game_over};
  endfunction

  function automatic logic [5:0] exp_vec();
    logic inv;
    logic [1:0] l;
    inv = m_playing && (m_inv_left > 0);
    l   = 2'(m_lives);
    return {m_pulse, l, inv, inv && ((m_inv_left >> 2) & 1) == 1, m_over};
  endfunction

  task automatic step(input logic r, input logic [9:0] row, input logic [9:0] col,
                      input logic von, input logic [11:0] o, input logic [11:0] p,
                      input logic st);
    bit tk, px, hit, idle, clr_over;
    reset = r; pix_row = row; pix_col = col; video_on = von;
    obstacle_pix = o; player_pix = p; start = st;
    @(posedge clk);
    if (r) begin
      m_count = 0; m_playing = 0; m_over = 0; m_lives = 3; m_inv_left = 0; m_pulse = 0;
    end else begin
      tk       = (row == 10'd480) && (col == 10'd0);
      px       = von && (o != 12'h000) && (p != 12'h000);
      hit      = (m_count >= 16);
      idle     = !m_playing && !m_over;
      clr_over = st && m_over;
      m_pulse  = 0;
      if (st && (idle || m_over)) begin
        m_playing = 1; m_over = 0; m_lives = 3; m_inv_left = 0;
      end else if (tk && m_playing) begin
        if (m_inv_left > 0) begin
          m_inv_left--;
        end else if (hit) begin
          m_pulse = 1;
          if (m_lives > 1) begin
            m_lives--; m_inv_left = 60;
          end else begin
            m_lives = 0; m_playing = 0; m_over = 1;
          end
        end
      end
      if (tk || clr_over) m_count = 0;
      else if (px && m_count < 4095) m_count++;
    end
    #1;
  endtask

  task automatic idle_cycle(input logic st);
    step(1'b0, 10'd500, 10'd7, 1'b0, 12'h000, 12'h000, st);
  endtask

  // One compressed frame: n_ovl overlapping pixels and n_noise near-misses in
  // random order, then the tick pixel. rows>0 confines overlaps to that many rows.
  task automatic run_frame(input int n_ovl, input int n_noise, input bit st_tick,
                           input int st_rate, input int rows);
    int a, b, kind;
    logic [9:0] row, col;
    logic [11:0] o, p;
    logic von, st;
    a = n_ovl; b = n_noise;
    while (a + b > 0) begin
      o = 12'($urandom_range(4095, 1));
      p = 12'($urandom_range(4095, 1));
      row = (rows > 0) ? 10'(100 + $urandom_range(rows - 1)) : 10'($urandom_range(479));
      col = 10'($urandom_range(639));
      von = 1'b1;
      if ($urandom_range(a + b - 1) < a) begin
        a--;
      end else begin
        b--;
        kind = $urandom_range(2);
        if (kind == 0) p = 12'h000;
        else if (kind == 1) o = 12'h000;
        else begin
          von = 1'b0; row = 10'($urandom_range(524, 481)); col = 10'($urandom_range(799, 1));
        end
      end
      st = (st_rate > 0) && ($urandom_range(st_rate - 1) == 0);
      step(1'b0, row, col, von, o, p, st);
    end
    step(1'b0, 10'd480, 10'd0, 1'b0, 12'($urandom), 12'($urandom), st_tick);
  endtask

  task automatic test_reset();
    step(1'b1, 10'd500, 10'd5, 1'b0, 12'h000, 12'h000, 1'b0);
    step(1'b1, 10'd500, 10'd5, 1'b1, 12'hFFF, 12'hFFF, 1'b1);
    n_cmp++;
    if (dut_vec() !== 6'b0_11_000) begin
      n_bad++; $display("FAIL reset_state: got %b expected %b", dut_vec(), 6'b0_11_000);
    end
    idle_cycle(1'b0);
    run_frame(25, 3, 1'b0, 0, 0);
    n_cmp++;
    if (dut_vec() !== 6'b0_11_000 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL idle_tick_ignored: got %b expected %b", dut_vec(), 6'b0_11_000);
    end
  endtask

  task automatic test_first_hit();
    idle_cycle(1'b1);
    n_cmp++;
    if (dut_vec() !== 6'b0_11_000) begin
      n_bad++; $display("FAIL start_play: got %b expected %b", dut_vec(), 6'b0_11_000);
    end
    run_frame(20, 5, 1'b0, 0, 0);
    n_cmp++;
    if (dut_vec() !== 6'b1_10_110 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL first_hit: got %b expected %b", dut_vec(), 6'b1_10_110);
    end
    idle_cycle(1'b0);
    n_cmp++;
    if (dut_vec() !== 6'b0_10_110) begin
      n_bad++; $display("FAIL pulse_one_cycle: got %b expected %b", dut_vec(), 6'b0_10_110);
    end
  endtask

  task automatic test_invuln();
    logic [5:0] want;
    logic inv, fl;
    for (int k = 1; k <= 60; k++) begin
      run_frame(100, 0, 1'b0, 4, 0);
      inv  = (k < 60);
      fl   = inv && ((((60 - k) >> 2) & 1) == 1);
      want = {1'b0, 2'd2, inv, fl, 1'b0};
      n_cmp++;
      if (dut_vec() !== want || dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL invuln_frame_%0d: got %b expected %b", k, dut_vec(), want);
      end
    end
    run_frame(0, 3, 1'b0, 0, 0);
    n_cmp++;
    if (dut_vec() !== 6'b0_10_000) begin
      n_bad++; $display("FAIL invuln_over: got %b expected %b", dut_vec(), 6'b0_10_000);
    end
  endtask

  task automatic test_threshold();
    step(1'b1, 10'd500, 10'd5, 1'b0, 12'h000, 12'h000, 1'b0);
    idle_cycle(1'b1);
    run_frame(15, 6, 1'b0, 0, 0);
    n_cmp++;
    if (dut_vec() !== 6'b0_11_000 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL below_threshold: got %b expected %b", dut_vec(), 6'b0_11_000);
    end
    run_frame(16, 6, 1'b0, 0, 2);
    n_cmp++;
    if (dut_vec() !== 6'b1_10_110 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL at_threshold: got %b expected %b", dut_vec(), 6'b1_10_110);
    end
  endtask

  task automatic test_game_over();
    for (int k = 0; k < 60; k++) run_frame(0, 2, 1'b0, 0, 0);
    run_frame(17, 2, 1'b0, 0, 0);
    n_cmp++;
    if (dut_vec() !== 6'b1_01_110 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL second_hit: got %b expected %b", dut_vec(), 6'b1_01_110);
    end
    for (int k = 0; k < 60; k++) run_frame(0, 2, 1'b0, 0, 0);
    run_frame(30, 2, 1'b0, 0, 0);
    n_cmp++;
    if (dut_vec() !== 6'b1_00_001 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL fatal_hit: got %b expected %b", dut_vec(), 6'b1_00_001);
    end
    for (int k = 0; k < 3; k++) begin
      run_frame(40, 1, 1'b0, 0, 0);
      n_cmp++;
      if (dut_vec() !== 6'b0_00_001) begin
        n_bad++; $display("FAIL over_no_pulse_%0d: got %b expected %b", k, dut_vec(), 6'b0_00_001);
      end
    end
  endtask

  task automatic test_restart_tick();
    run_frame(30, 2, 1'b1, 0, 0);
    n_cmp++;
    if (dut_vec() !== 6'b0_11_000 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL restart_on_tick: got %b expected %b", dut_vec(), 6'b0_11_000);
    end
    run_frame(10, 2, 1'b0, 0, 0);
    n_cmp++;
    if (dut_vec() !== 6'b0_11_000) begin
      n_bad++; $display("FAIL after_restart: got %b expected %b", dut_vec(), 6'b0_11_000);
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 10; i++)
      step(1'b0, 10'd200, 10'(i), 1'b1, 12'h0F0, 12'hF00, 1'b0);
    step(1'b1, 10'd200, 10'd20, 1'b0, 12'h000, 12'h000, 1'b0);
    n_cmp++;
    if (dut_vec() !== 6'b0_11_000) begin
      n_bad++; $display("FAIL midframe_reset: got %b expected %b", dut_vec(), 6'b0_11_000);
    end
    idle_cycle(1'b1);
    for (int i = 0; i < 10; i++)
      step(1'b0, 10'd210, 10'(i), 1'b1, 12'h0F0, 12'hF00, 1'b0);
    step(1'b0, 10'd480, 10'd0, 1'b0, 12'h000, 12'h000, 1'b0);
    n_cmp++;
    if (dut_vec() !== 6'b0_11_000 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL count_restarted: got %b expected %b", dut_vec(), 6'b0_11_000);
    end
  endtask

  task automatic test_saturation();
    run_frame(4101, 0, 1'b0, 0, 0);
    n_cmp++;
    if (dut_vec() !== 6'b1_10_110 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL saturate_hit: got %b expected %b", dut_vec(), 6'b1_10_110);
    end
  endtask

  task automatic test_back_to_back_random();
    step(1'b1, 10'd500, 10'd5, 1'b0, 12'h000, 12'h000, 1'b0);
    idle_cycle(1'b1);
    for (int f = 0; f < 220; f++) begin
      run_frame($urandom_range(24), $urandom_range(3), 1'($urandom_range(7) == 0), 12, 0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL random_frame_%0d: got %b expected %b", f, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_hit();
    test_invuln();
    test_threshold();
    test_game_over();
    test_restart_tick();
    test_reset_midframe();
    test_saturation();
    test_back_to_back_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
